ssm_y_stream_out: RTL and testbench

Output-side serializer for ssm_block_fp16_top. When the SSM block pulses done, this block captures the flat fp16 result bus y_flat into a shadow register. It then streams the result one DW-bit word per transfer over a valid/ready interface, so results leave the accelerator as an ordered word stream rather than a wide bus. Word order matches the flat packing: word i = y_flat[DW*i +: DW], i = 0 first.

---
 rtl/ssm_y_stream_out.sv | 95 +++++++++
 tb/tb_ssm_y_stream_out.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssm_y_stream_out.sv
// Output serializer for the SSM block: captures the flat fp16 result bus on done_in
// and streams it one DW-bit word per valid/ready transfer, word 0 first.
module ssm_y_stream_out #(
   parameter int unsigned B  = 1,
   parameter int unsigned H  = 4,
   parameter int unsigned P  = 4,
   parameter int unsigned DW = 16,
   localparam int unsigned NW = B * H * P,
   localparam int unsigned IW = (NW > 1) ? $clog2(NW) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             done_in,
   input  logic [NW*DW-1:0] y_flat,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [DW-1:0]    m_data,
   output logic [IW-1:0]    m_index,
   output logic             m_last,
   output logic             busy,
   output logic             frame_done,
   output logic             drop_err
);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t          state;
   logic [DW-1:0]   shadow [NW];
   logic            is_last;
   logic            capture;
   logic [IW-1:0]   idx_next;

   assign is_last  = (m_index == IW'(NW - 1));
   // A new frame is accepted when idle, or on the very edge the last word leaves.
   assign capture  = done_in && ((state == IDLE) || (m_ready && is_last));
   assign idx_next = m_index + IW'(1);
   assign m_last   = m_valid && is_last;

   // Shadow copy of the result frame; contents are meaningless until first capture.
   always_ff @(posedge clk) begin
      if (capture) begin
         for (int i = 0; i < int'(NW); i++) begin
            shadow[i] <= y_flat[DW*i +: DW];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         m_valid    <= 1'b0;
         m_data     <= '0;
         m_index    <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         drop_err   <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (capture) begin
                  state   <= STREAM;
                  m_valid <= 1'b1;
                  busy    <= 1'b1;
                  m_index <= '0;
                  m_data  <= y_flat[DW-1:0];
               end
            end
            STREAM: begin
               if (m_ready && is_last) begin
                  frame_done <= 1'b1;
                  if (capture) begin
                     m_index <= '0;
                     m_data  <= y_flat[DW-1:0];
                  end else begin
                     state   <= IDLE;
                     m_valid <= 1'b0;
                     busy    <= 1'b0;
                     m_index <= '0;
                     m_data  <= '0;
                  end
               end else begin
                  // Frame arriving mid-stream cannot be buffered: flag and drop it.
                  if (done_in) drop_err <= 1'b1;
                  if (m_ready) begin
                     m_index <= idx_next;
                     m_data  <= shadow[idx_next];
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ssm_y_stream_out.sv
// Directed self-checking bench for ssm_y_stream_out (default NW=16 frame).
module tb_ssm_y_stream_out;

   localparam int unsigned NW = 16;
   localparam int unsigned DW = 16;
   localparam int unsigned IW = 4;

   logic             clk;
   logic             rst;
   logic             done_in;
   logic [NW*DW-1:0] y_flat;
   logic             m_valid;
   logic             m_ready;
   logic [DW-1:0]    m_data;
   logic [IW-1:0]    m_index;
   logic             m_last;
   logic             busy;
   logic             frame_done;
   logic             drop_err;

   int errors = 0;
   int checks = 0;

   ssm_y_stream_out dut (
      .clk        (clk),
      .rst        (rst),
      .done_in    (done_in),
      .y_flat     (y_flat),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_index    (m_index),
      .m_last     (m_last),
      .busy       (busy),
      .frame_done (frame_done),
      .drop_err   (drop_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_frame(input logic [15:0] base);
      for (int i = 0; i < int'(NW); i++) y_flat[16*i +: 16] = base + 16'(i);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1; done_in = 1'b0; m_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; done_in = 1'b0; m_ready = 1'b0; y_flat = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({m_valid, m_data, m_index, m_last, busy, frame_done, drop_err} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%b d=%h i=%0d l=%b b=%b fd=%b de=%b want all 0",
                  m_valid, m_data, m_index, m_last, busy, frame_done, drop_err);
      end
      rst = 1'b0;
      @(negedge clk);
      m_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_ignores_ready: got v=%b b=%b want 0 0", m_valid, busy);
      end
   endtask

   task automatic test_single_frame();
      set_frame(16'h3C00); done_in = 1'b1; m_ready = 1'b1;
      @(negedge clk);
      done_in = 1'b0;
      for (int i = 0; i < int'(NW); i++) begin
         checks++;
         if (m_valid !== 1'b1 || busy !== 1'b1 || m_data !== 16'h3C00 + 16'(i) ||
             m_index !== IW'(i) || m_last !== (i == int'(NW) - 1) || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL single_word%0d: got v=%b b=%b d=%h i=%0d l=%b fd=%b want 1 1 %h %0d %b 0",
                     i, m_valid, busy, m_data, m_index, m_last, frame_done,
                     16'h3C00 + 16'(i), i, i == int'(NW) - 1);
         end
         @(negedge clk);
      end
      checks++;
      if (frame_done !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0 || m_last !== 1'b0) begin
         errors++;
         $display("FAIL single_end: got fd=%b v=%b b=%b l=%b want 1 0 0 0",
                  frame_done, m_valid, busy, m_last);
      end
      @(negedge clk);
      checks++;
      if (frame_done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_fd_pulse: got fd=%b b=%b want 0 0", frame_done, busy);
      end
   endtask

   task automatic test_backpressure();
      logic [3:0] pat;
      int exp_idx;
      int cyc;
      pat = 4'b1001;
      exp_idx = 0;
      cyc = 0;
      set_frame(16'h3C00); done_in = 1'b1; m_ready = 1'b0;
      @(negedge clk);
      done_in = 1'b0;
      while (exp_idx < int'(NW) && cyc < 200) begin
         checks++;
         if (m_valid !== 1'b1 || m_data !== 16'h3C00 + 16'(exp_idx) || m_index !== IW'(exp_idx)) begin
            errors++;
            $display("FAIL bp_cycle%0d: got v=%b d=%h i=%0d want 1 %h %0d",
                     cyc, m_valid, m_data, m_index, 16'h3C00 + 16'(exp_idx), exp_idx);
         end
         m_ready = pat[cyc % 4];
         if (m_ready) exp_idx++;
         cyc++;
         @(negedge clk);
      end
      checks++;
      if (exp_idx != int'(NW)) begin
         errors++;
         $display("FAIL bp_timeout: got %0d words want %0d", exp_idx, NW);
      end
      checks++;
      if (frame_done !== 1'b1 || m_valid !== 1'b0 || drop_err !== 1'b0) begin
         errors++;
         $display("FAIL bp_end: got fd=%b v=%b de=%b want 1 0 0", frame_done, m_valid, drop_err);
      end
      m_ready = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_drop();
      set_frame(16'h3C00); done_in = 1'b1; m_ready = 1'b1;
      @(negedge clk);
      done_in = 1'b0;
      for (int i = 0; i < int'(NW); i++) begin
         checks++;
         if (m_valid !== 1'b1 || m_data !== 16'h3C00 + 16'(i) || m_index !== IW'(i)) begin
            errors++;
            $display("FAIL drop_word%0d: got v=%b d=%h i=%0d want 1 %h %0d",
                     i, m_valid, m_data, m_index, 16'h3C00 + 16'(i), i);
         end
         if (i == 5) begin
            set_frame(16'hBC00); done_in = 1'b1;
         end else begin
            done_in = 1'b0;
         end
         @(negedge clk);
         if (i == 5) begin
            checks++;
            if (drop_err !== 1'b1) begin
               errors++;
               $display("FAIL drop_flag: got de=%b want 1", drop_err);
            end
         end
      end
      checks++;
      if (frame_done !== 1'b1 || m_valid !== 1'b0) begin
         errors++;
         $display("FAIL drop_end: got fd=%b v=%b want 1 0", frame_done, m_valid);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (drop_err !== 1'b1 || m_valid !== 1'b0) begin
         errors++;
         $display("FAIL drop_sticky: got de=%b v=%b want 1 0", drop_err, m_valid);
      end
   endtask

   task automatic test_back_to_back();
      int fd_count;
      fd_count = 0;
      set_frame(16'h3C00); done_in = 1'b1; m_ready = 1'b1;
      @(negedge clk);
      done_in = 1'b0;
      for (int i = 0; i < int'(NW); i++) begin
         checks++;
         if (m_valid !== 1'b1 || m_data !== 16'h3C00 + 16'(i) || m_index !== IW'(i)) begin
            errors++;
            $display("FAIL b2b_a_word%0d: got v=%b d=%h i=%0d want 1 %h %0d",
                     i, m_valid, m_data, m_index, 16'h3C00 + 16'(i), i);
         end
         if (frame_done === 1'b1) fd_count++;
         if (i == int'(NW) - 1) begin
            set_frame(16'hBC00); done_in = 1'b1;
         end
         @(negedge clk);
      end
      done_in = 1'b0;
      for (int i = 0; i < int'(NW); i++) begin
         checks++;
         if (m_valid !== 1'b1 || m_data !== 16'hBC00 + 16'(i) || m_index !== IW'(i) ||
             drop_err !== 1'b0 || frame_done !== (i == 0)) begin
            errors++;
            $display("FAIL b2b_b_word%0d: got v=%b d=%h i=%0d de=%b fd=%b want 1 %h %0d 0 %b",
                     i, m_valid, m_data, m_index, drop_err, frame_done,
                     16'hBC00 + 16'(i), i, i == 0);
         end
         if (frame_done === 1'b1) fd_count++;
         @(negedge clk);
      end
      if (frame_done === 1'b1) fd_count++;
      checks++;
      if (m_valid !== 1'b0 || fd_count != 2) begin
         errors++;
         $display("FAIL b2b_end: got v=%b frame_done_pulses=%0d want 0 2", m_valid, fd_count);
      end
   endtask

   task automatic test_async_reset();
      set_frame(16'h3C00); done_in = 1'b1; m_ready = 1'b1;
      @(negedge clk);
      done_in = 1'b0;
      repeat (7) @(negedge clk);
      checks++;
      if (m_index !== IW'(7) || m_data !== 16'h3C07) begin
         errors++;
         $display("FAIL arst_pre: got i=%0d d=%h want 7 3c07", m_index, m_data);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({m_valid, m_data, m_index, m_last, busy, frame_done, drop_err} !== '0) begin
         errors++;
         $display("FAIL arst_async: got v=%b d=%h i=%0d l=%b b=%b fd=%b de=%b want all 0",
                  m_valid, m_data, m_index, m_last, busy, frame_done, drop_err);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL arst_idle: got v=%b b=%b want 0 0", m_valid, busy);
      end
      set_frame(16'h4400); done_in = 1'b1;
      @(negedge clk);
      done_in = 1'b0;
      for (int i = 0; i < int'(NW); i++) begin
         checks++;
         if (m_valid !== 1'b1 || m_data !== 16'h4400 + 16'(i) || m_index !== IW'(i)) begin
            errors++;
            $display("FAIL arst_word%0d: got v=%b d=%h i=%0d want 1 %h %0d",
                     i, m_valid, m_data, m_index, 16'h4400 + 16'(i), i);
         end
         @(negedge clk);
      end
      checks++;
      if (frame_done !== 1'b1 || m_valid !== 1'b0) begin
         errors++;
         $display("FAIL arst_end: got fd=%b v=%b want 1 0", frame_done, m_valid);
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_backpressure();
      test_drop();
      apply_reset();
      test_back_to_back();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
